// File: rtl/dual_port_ram_if.sv
// Control and registered-read-data bundle for both ports of dual_port_ram.
// The bidirectional data buses are module ports, so tristate resolution stays at the RAM boundary.
interface dual_port_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  cs_a;
    logic                  cs_b;
    logic                  we_a;
    logic                  we_b;
    logic                  oe_a;
    logic                  oe_b;
    logic [DATA_WIDTH-1:0] data_a_out;
    logic [DATA_WIDTH-1:0] data_b_out;

    modport master (
        output addr_a, addr_b, cs_a, cs_b, we_a, we_b, oe_a, oe_b,
        input  data_a_out, data_b_out
    );

    modport slave (
        input  addr_a, addr_b, cs_a, cs_b, we_a, we_b, oe_a, oe_b,
        output data_a_out, data_b_out
    );
endinterface

// File: rtl/dual_port_ram.sv
// True dual-port RAM, one-cycle registered reads, read-first, port B wins write collisions.
// Optional DPRAM_MEM_CLEAR_EN: reset also zeroes every memory word.
module dual_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] data_a,
    inout  wire  [DATA_WIDTH-1:0] data_b,
    dual_port_ram_if.slave        bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_a_out_q, data_a_out_d;
    logic [DATA_WIDTH-1:0] data_b_out_q, data_b_out_d;
    logic                  wr_a, wr_b, rd_a, rd_b;
    logic                  drv_a, drv_b;

    always_comb begin
        wr_a = 1'b0;
        wr_b = 1'b0;
        rd_a = 1'b0;
        rd_b = 1'b0;
        if (!rst) begin
            wr_b = bus.cs_b & bus.we_b;
            // On a same-address double write only port B's data lands.
            wr_a = bus.cs_a & bus.we_a & ~(wr_b & (bus.addr_a == bus.addr_b));
            rd_a = bus.cs_a & ~bus.we_a & bus.oe_a;
            rd_b = bus.cs_b & ~bus.we_b & bus.oe_b;
        end
    end

    // mem is read before this edge's writes commit, giving read-first behaviour.
    always_comb begin
        data_a_out_d = data_a_out_q;
        data_b_out_d = data_b_out_q;
        if (rd_a) data_a_out_d = mem[bus.addr_a];
        if (rd_b) data_b_out_d = mem[bus.addr_b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_a_out_q <= '0;
            data_b_out_q <= '0;
        end else begin
            data_a_out_q <= data_a_out_d;
            data_b_out_q <= data_b_out_d;
        end
    end

`ifdef DPRAM_MEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_a) mem[bus.addr_a] <= data_a;
            if (wr_b) mem[bus.addr_b] <= data_b;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (wr_a) mem[bus.addr_a] <= data_a;
        if (wr_b) mem[bus.addr_b] <= data_b;
    end
`endif

    // Bus enables stay combinational so they track cs/oe/we even during reset.
    assign drv_a = bus.cs_a & bus.oe_a & ~bus.we_a;
    assign drv_b = bus.cs_b & bus.oe_b & ~bus.we_b;
    assign data_a = drv_a ? data_a_out_q : {DATA_WIDTH{1'bz}};
    assign data_b = drv_b ? data_b_out_q : {DATA_WIDTH{1'bz}};

    assign bus.data_a_out = data_a_out_q;
    assign bus.data_b_out = data_b_out_q;
endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: a reference memory model predicts each edge's results.
module tb_dual_port_ram;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int DEPTH = 64;

    // op codes: 0 = deselected (oe held high), 1 = read, 2 = write, 3 = selected, oe low
    localparam int OP_IDLE = 0;
    localparam int OP_RD   = 1;
    localparam int OP_WR   = 2;
    localparam int OP_NOE  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    wire  [DW-1:0] data_a;
    wire  [DW-1:0] data_b;
    logic [DW-1:0] tb_dat_a = '0;
    logic [DW-1:0] tb_dat_b = '0;
    logic          tb_drv_a = 1'b0;
    logic          tb_drv_b = 1'b0;

    assign data_a = tb_drv_a ? tb_dat_a : {DW{1'bz}};
    assign data_b = tb_drv_b ? tb_dat_b : {DW{1'bz}};

    dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .data_a (data_a),
        .data_b (data_b),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] exp_a = '0;
    logic [DW-1:0] exp_b = '0;
    logic [DW-1:0] q_a [$];
    logic [DW-1:0] q_b [$];

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive_a(input int op, input int adr, input logic [DW-1:0] dat);
        bus.addr_a = adr[AW-1:0];
        bus.cs_a   = (op != OP_IDLE);
        bus.we_a   = (op == OP_WR);
        bus.oe_a   = (op != OP_NOE) && (op != OP_WR);
        tb_drv_a   = (op == OP_WR);
        tb_dat_a   = dat;
    endtask

    task automatic drive_b(input int op, input int adr, input logic [DW-1:0] dat);
        bus.addr_b = adr[AW-1:0];
        bus.cs_b   = (op != OP_IDLE);
        bus.we_b   = (op == OP_WR);
        bus.oe_b   = (op != OP_NOE) && (op != OP_WR);
        tb_drv_b   = (op == OP_WR);
        tb_dat_b   = dat;
    endtask

    // One clock edge: drive both ports, predict, then compare just after the edge.
    task automatic step(input int a_op, input int a_adr, input logic [DW-1:0] a_dat,
                        input int b_op, input int b_adr, input logic [DW-1:0] b_dat,
                        input logic r);
        logic [DW-1:0] old_a;
        logic [DW-1:0] old_b;
        logic [DW-1:0] got;
        drive_a(a_op, a_adr, a_dat);
        drive_b(b_op, b_adr, b_dat);
        rst = r;
        old_a = mdl[a_adr];
        old_b = mdl[b_adr];
        if (r) begin
            exp_a = '0;
            exp_b = '0;
`ifdef DPRAM_MEM_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
`endif
        end else begin
            if (a_op == OP_RD) exp_a = old_a;
            if (b_op == OP_RD) exp_b = old_b;
            if (a_op == OP_WR) mdl[a_adr] = a_dat;
            if (b_op == OP_WR) mdl[b_adr] = b_dat;
        end
        q_a.push_back(exp_a);
        q_b.push_back(exp_b);
        @(posedge clk);
        #1;
        got = q_a.pop_front();
        check("out_a", bus.data_a_out, got);
        check("drv_a", {31'd0, dut.drv_a}, {31'd0, a_op == OP_RD});
        if (a_op == OP_RD) check("bus_a", data_a, got);
        if (a_op == OP_WR) check("wbus_a", data_a, a_dat);
        got = q_b.pop_front();
        check("out_b", bus.data_b_out, got);
        check("drv_b", {31'd0, dut.drv_b}, {31'd0, b_op == OP_RD});
        if (b_op == OP_RD) check("bus_b", data_b, got);
        if (b_op == OP_WR) check("wbus_b", data_b, b_dat);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;
        drive_a(OP_IDLE, 0, '0);
        drive_b(OP_IDLE, 0, '0);

        // Reset state
        step(OP_IDLE, 0, '0, OP_IDLE, 0, '0, 1'b1);
        step(OP_IDLE, 0, '0, OP_IDLE, 0, '0, 1'b1);
        step(OP_IDLE, 0, '0, OP_IDLE, 0, '0, 1'b0);

        // Fill through port A, then read everything back
        for (int i = 0; i < DEPTH; i++) step(OP_WR, i, $urandom, OP_IDLE, 0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(OP_RD, i, '0, OP_IDLE, 0, '0, 1'b0);

        // Cross-port write then read
        step(OP_WR, 5, 32'hDEADBEEF, OP_IDLE, 0, '0, 1'b0);
        step(OP_IDLE, 0, '0, OP_RD, 5, '0, 1'b0);
        check("xport_5", bus.data_b_out, 32'hDEADBEEF);

        // Same-address write collision
        step(OP_WR, 9, 32'h11111111, OP_WR, 9, 32'h22222222, 1'b0);
        step(OP_RD, 9, '0, OP_RD, 9, '0, 1'b0);
        check("collide_9", bus.data_a_out, 32'h22222222);

        // Read-first across ports
        step(OP_WR, 3, 32'h0, OP_IDLE, 0, '0, 1'b0);
        step(OP_WR, 3, 32'h33333333, OP_RD, 3, '0, 1'b0);
        check("rdfirst_3", bus.data_b_out, 32'h0);
        step(OP_IDLE, 0, '0, OP_RD, 3, '0, 1'b0);
        check("after_3", bus.data_b_out, 32'h33333333);

        // Bus release cases; the out register must hold through them
        step(OP_NOE, 7, '0, OP_NOE, 8, '0, 1'b0);
        step(OP_IDLE, 7, '0, OP_IDLE, 8, '0, 1'b0);
        step(OP_RD, 7, '0, OP_RD, 8, '0, 1'b0);

        // Reset in the middle of a read stream, with a write presented on the reset edge
        step(OP_WR, 20, 32'hA5A5A5A5, OP_IDLE, 0, '0, 1'b0);
        step(OP_RD, 10, '0, OP_RD, 11, '0, 1'b0);
        step(OP_RD, 11, '0, OP_WR, 20, 32'h5A5A5A5A, 1'b1);
        step(OP_RD, 12, '0, OP_IDLE, 0, '0, 1'b0);
        step(OP_IDLE, 0, '0, OP_RD, 20, '0, 1'b0);
`ifdef DPRAM_MEM_CLEAR_EN
        check("rst_keep_20", bus.data_b_out, 32'h0);
`else
        check("rst_keep_20", bus.data_b_out, 32'hA5A5A5A5);
`endif
        if ($isunknown(mdl[12])) step(OP_WR, 12, 32'h0, OP_IDLE, 0, '0, 1'b0);

        // Refill so random traffic never reads unknown words
        for (int i = 0; i < DEPTH; i++) step(OP_WR, i, $urandom, OP_WR, (i + 32) % DEPTH, $urandom, 1'b0);

        // Random concurrent traffic on a narrow address window to provoke collisions
        for (int n = 0; n < 300; n++) begin
            step(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
